// File: rtl/aead_stream_sequencer.sv
// Per-message AEAD control: keystream request, AAD/payload forwarding with keep
// checking and byte counting, length block, tag wait, all wait states watchdog-guarded.
module aead_stream_sequencer #(
  parameter int CNT_W  = 32,
  parameter int WDOG_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               algo_sel,
  input  logic               aad_empty,
  input  logic               pld_empty,
  input  logic               abort,
  input  logic               s_aad_valid,
  output logic               s_aad_ready,
  input  logic [127:0]       s_aad_data,
  input  logic [15:0]        s_aad_keep,
  input  logic               s_aad_last,
  input  logic               s_pld_valid,
  output logic               s_pld_ready,
  input  logic [127:0]       s_pld_data,
  input  logic [15:0]        s_pld_keep,
  input  logic               s_pld_last,
  output logic               ks_req,
  input  logic               ks_valid,
  output logic               aad_valid,
  input  logic               aad_ready,
  output logic [127:0]       aad_data,
  output logic [15:0]        aad_keep,
  output logic               pld_valid,
  input  logic               pld_ready,
  output logic [127:0]       pld_data,
  output logic [15:0]        pld_keep,
  output logic               len_valid,
  input  logic               len_ready,
  output logic [127:0]       len_block,
  input  logic               aad_done,
  input  logic               pld_done,
  input  logic               lens_done,
  input  logic               tag_pre_xor_valid,
  input  logic               tagmask_valid,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic               err_proto,
  output logic [CNT_W-1:0]   aad_bytes,
  output logic [CNT_W-1:0]   pld_bytes
);

  typedef enum logic [3:0] {
    S_IDLE, S_KS, S_AAD, S_AAD_W, S_PLD, S_PLD_W, S_LEN, S_LEN_W, S_TAG, S_DONE, S_ERR
  } state_t;

  state_t              state;
  logic                algo_q, aad_empty_q, pld_empty_q;
  logic                pre_seen, mask_seen;
  logic [WDOG_W-1:0]   wdog;

  function automatic logic [4:0] popcount16(input logic [15:0] k);
    popcount16 = '0;
    for (int i = 0; i < 16; i++) popcount16 = popcount16 + {4'd0, k[i]};
  endfunction

  // Last beat must be 2^n-1 (contiguous from lane 0) and nonzero.
  function automatic logic keep_ok(input logic [15:0] k, input logic last);
    logic [15:0] k1;
    k1 = k + 16'd1;
    if (!last) keep_ok = (k == 16'hFFFF);
    else       keep_ok = (k != 16'h0) && ((k1 & k) == 16'h0);
  endfunction

  function automatic logic [127:0] make_len(input logic chacha,
                                            input logic [CNT_W-1:0] a,
                                            input logic [CNT_W-1:0] p);
    logic [63:0] a64, p64;
    a64 = 64'(a);
    p64 = 64'(p);
    if (chacha) make_len = {p64, a64};
    else        make_len = {a64 << 3, p64 << 3};
  endfunction

  logic               aad_hs, pld_hs;
  logic [15:0]        beat_keep;
  logic               beat_last, beat_bad;
  logic [CNT_W:0]     cnt_sum;
  logic [WDOG_W-1:0]  wdog_inc;
  logic               wdog_fire;
  logic               pre_now, mask_now;
  logic [127:0]       len_word;

  assign aad_valid   = (state == S_AAD) && s_aad_valid;
  assign s_aad_ready = (state == S_AAD) && aad_ready;
  assign aad_data    = s_aad_data;
  assign aad_keep    = s_aad_keep;
  assign pld_valid   = (state == S_PLD) && s_pld_valid;
  assign s_pld_ready = (state == S_PLD) && pld_ready;
  assign pld_data    = s_pld_data;
  assign pld_keep    = s_pld_keep;

  assign aad_hs    = aad_valid && aad_ready;
  assign pld_hs    = pld_valid && pld_ready;
  assign beat_keep = (state == S_AAD) ? s_aad_keep : s_pld_keep;
  assign beat_last = (state == S_AAD) ? s_aad_last : s_pld_last;
  assign cnt_sum   = {1'b0, ((state == S_AAD) ? aad_bytes : pld_bytes)}
                   + (CNT_W+1)'(popcount16(beat_keep));
  assign beat_bad  = !keep_ok(beat_keep, beat_last) || cnt_sum[CNT_W];

  // Watchdog fires once 2^WDOG_W-1 idle cycles have elapsed in a core wait state.
  assign wdog_inc  = wdog + WDOG_W'(1);
  assign wdog_fire = (wdog_inc == '1);
  assign pre_now   = pre_seen  || tag_pre_xor_valid;
  assign mask_now  = mask_seen || tagmask_valid;
  assign len_word  = make_len(algo_q, aad_bytes, pld_bytes);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      algo_q      <= 1'b0;
      aad_empty_q <= 1'b0;
      pld_empty_q <= 1'b0;
      pre_seen    <= 1'b0;
      mask_seen   <= 1'b0;
      wdog        <= '0;
      ks_req      <= 1'b0;
      len_valid   <= 1'b0;
      len_block   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_proto   <= 1'b0;
      aad_bytes   <= '0;
      pld_bytes   <= '0;
    end else begin
      ks_req <= 1'b0;
      done   <= 1'b0;
      wdog   <= '0;
      if (abort) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        len_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            state       <= S_KS;
            busy        <= 1'b1;
            ks_req      <= 1'b1;
            algo_q      <= algo_sel;
            aad_empty_q <= aad_empty;
            pld_empty_q <= pld_empty;
            aad_bytes   <= '0;
            pld_bytes   <= '0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
            pre_seen    <= 1'b0;
            mask_seen   <= 1'b0;
          end
          S_KS: if (ks_valid) begin
            if (!aad_empty_q)      state <= S_AAD;
            else if (!pld_empty_q) state <= S_PLD;
            else begin
              state     <= S_LEN;
              len_valid <= 1'b1;
              len_block <= len_word;
            end
          end else if (wdog_fire) begin
            err_timeout <= 1'b1;
            state       <= S_ERR;
          end else wdog <= wdog_inc;
          S_AAD: if (aad_hs) begin
            aad_bytes <= cnt_sum[CNT_W-1:0];
            if (beat_bad) begin
              err_proto <= 1'b1;
              state     <= S_ERR;
            end else if (s_aad_last) state <= S_AAD_W;
          end
          S_AAD_W: if (aad_done) begin
            if (!pld_empty_q) state <= S_PLD;
            else begin
              state     <= S_LEN;
              len_valid <= 1'b1;
              len_block <= len_word;
            end
          end else if (wdog_fire) begin
            err_timeout <= 1'b1;
            state       <= S_ERR;
          end else wdog <= wdog_inc;
          S_PLD: if (pld_hs) begin
            pld_bytes <= cnt_sum[CNT_W-1:0];
            if (beat_bad) begin
              err_proto <= 1'b1;
              state     <= S_ERR;
            end else if (s_pld_last) state <= S_PLD_W;
          end
          S_PLD_W: if (pld_done) begin
            state     <= S_LEN;
            len_valid <= 1'b1;
            len_block <= len_word;
          end else if (wdog_fire) begin
            err_timeout <= 1'b1;
            state       <= S_ERR;
          end else wdog <= wdog_inc;
          S_LEN: if (len_ready) begin
            len_valid <= 1'b0;
            state     <= S_LEN_W;
          end else if (wdog_fire) begin
            len_valid   <= 1'b0;
            err_timeout <= 1'b1;
            state       <= S_ERR;
          end else wdog <= wdog_inc;
          S_LEN_W: if (lens_done) state <= S_TAG;
          else if (wdog_fire) begin
            err_timeout <= 1'b1;
            state       <= S_ERR;
          end else wdog <= wdog_inc;
          S_TAG: begin
            pre_seen  <= pre_now;
            mask_seen <= mask_now;
            if (pre_now && mask_now) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (wdog_fire) begin
              err_timeout <= 1'b1;
              state       <= S_ERR;
            end else wdog <= wdog_inc;
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          S_ERR: state <= S_ERR;
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
